neuron_mac_seq: RTL
===================

# neuron_mac_seq

Sequential multiply-accumulate stage for one four-input neuron. It drives the 2-bit select of the upstream 4-to-1, 4-bit input mux and consumes the mux output `y`, one input per cycle. Each of the four samples is multiplied by a per-input weight and summed into a registered weighted sum. Downstream activation and next-layer logic reads the sum on a one-cycle `done` pulse.

## Interface
- `DATA_W`, 4: width of the mux output / neuron input (unsigned).
- `WEIGHT_W`, 4: width of each weight (unsigned).
- `ACC_W`, 10: accumulator and sum width. Must be ≥ DATA_W+WEIGHT_W+2; 900 max fits in 10 bits.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a new accumulation; sampled only in IDLE or DONE.
- `weights`  in  4*WEIGHT_W  packed weights; w0 = [WEIGHT_W-1:0] pairs with sel 0, w3 = MSBs pairs with sel 3. Latched on start acceptance.
- `sel`  out  2  select to the upstream mux.
- `y`  in  DATA_W  mux output; combinational from `sel`, valid in the same cycle.
- `busy`  out  1  high while accumulating.
- `done`  out  1  one-cycle pulse; `sum` is valid from this cycle.
- `sum`  out  ACC_W  registered weighted sum; held until the next run completes.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start`=1 → RUN. Latch `weights`, clear the accumulator and the 2-bit counter `idx`.
  - RUN: `sel`=`idx`. Each cycle, acc ← acc + y·w[idx], and idx increments. When idx=3, the final sum is written to the `sum` register → DONE.
  - DONE: `done`=1 for exactly this cycle. `start`=1 → RUN with new weights latched (back-to-back runs). Otherwise → IDLE.
- `start` while in RUN is ignored. The run is not restarted and the weights are not relatched.
- `weights` changes after acceptance have no effect on the current run.
- `sel` = 0 in IDLE and DONE.
- Arithmetic is unsigned throughout. The product is DATA_W+WEIGHT_W bits, zero-extended to ACC_W. No overflow is possible at the default widths.
- Reset values (asserted at any time, including mid-RUN):
  - State → IDLE.
  - `sel`=0, `busy`=0, `done`=0, `sum`=0.
  - Accumulator, `idx` and latched weights = 0.
  - A partial run is discarded; `sum` does not reflect it.

## Timing
- `start` sampled high at edge T (IDLE):
  - Cycles T+1..T+4: `busy`=1, `sel`=0,1,2,3.
  - Cycle T+5: `done`=1, `busy`=0, new `sum` visible.
- Latency from `start` to `done` is 5 cycles. Peak throughput is one result per 5 cycles when `start` is held high.
- `y` is consumed in the same cycle `sel` is presented. The upstream mux is combinational, so there is no extra wait state.

## Configuration
- `NEURON_THRESH_EN` defined:
  - Adds input `thresh` [ACC_W-1:0] and output `fire` [1].
  - `fire` is registered alongside `sum`: `fire`=1 iff final sum ≥ `thresh`, with `thresh` sampled in the last RUN cycle.
  - `fire` reset value is 0 and it is held like `sum`.
- Undefined: no `thresh` or `fire` ports; the block outputs the raw sum only.

## Structure
- Shared package `ann_pkg`:
  - `DATA_W`, `WEIGHT_W`, `ACC_W` defaults.
  - State enum type `mac_state_t` (IDLE, RUN, DONE).
- Natural sub-module: `mac_acc`. It is the product-and-accumulate datapath, with clear and enable inputs and an ACC_W result. The FSM, `idx` counter and weight latch stay in the top level.

## Test plan
- Basic run: mux inputs A=1, B=2, C=3, D=4; weights w0..w3 = 1,2,3,4 (`weights`=16'h4321); pulse `start` → `sel` steps 0..3, `done` at T+5, `sum`=30.
- Maximum: all inputs 15, all weights 15 → `sum`=900, no wrap. All weights 0 → `sum`=0.
- Back-to-back: hold `start`=1 across DONE with new weights 16'h1111 and inputs 1,2,3,4 → second `done` 5 cycles after the first, `sum`=10. `start` pulses during RUN are ignored.
- Reset mid-run: deassert `rst_n` at T+2 → all outputs 0 immediately, no `done`, FSM in IDLE. A subsequent `start` produces a correct fresh result.
- `NEURON_THRESH_EN`: basic-run stimulus with `thresh`=30 → `fire`=1; with `thresh`=31 → `fire`=0.

Source files
------------

// File: rtl/ann_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ann_pkg
// Brief    : Shared widths and state encoding for the neuron MAC datapath.
// Revision : 1.0 - initial release
// ============================================================================
package ann_pkg;

    localparam int c_data_w   = 4;
    localparam int c_weight_w = 4;
    localparam int c_acc_w    = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mac_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : mac_acc
// Brief    : Unsigned product-and-accumulate datapath with clear and enable.
// Revision : 1.0 - initial release
// ============================================================================
module mac_acc
    import ann_pkg::*;
#(
    parameter int DATA_W   = c_data_w,
    parameter int WEIGHT_W = c_weight_w,
    parameter int ACC_W    = c_acc_w
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [DATA_W-1:0]   y,
    input  logic [WEIGHT_W-1:0] w,
    output logic [ACC_W-1:0]    acc,
    output logic [ACC_W-1:0]    acc_nxt
);

    localparam int PROD_W = DATA_W + WEIGHT_W;

    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  r_acc;

    assign w_prod  = y * w;
    // acc_nxt is exposed so the final sample can be folded into the result register directly
    assign acc_nxt = r_acc + {{(ACC_W-PROD_W){1'b0}}, w_prod};
    assign acc     = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= acc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/neuron_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac_seq
// Brief    : Four-input sequential neuron MAC driving an upstream 4:1 mux select.
//            Optional threshold compare/fire output under NEURON_THRESH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_mac_seq
    import ann_pkg::*;
#(
    parameter int DATA_W   = c_data_w,
    parameter int WEIGHT_W = c_weight_w,
    parameter int ACC_W    = c_acc_w
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*WEIGHT_W-1:0] weights,
    output logic [1:0]            sel,
    input  logic [DATA_W-1:0]     y,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_W-1:0]      sum
`ifdef NEURON_THRESH_EN
    ,
    input  logic [ACC_W-1:0]      thresh,
    output logic                  fire
`endif
);

    mac_state_t            r_state;
    logic [1:0]            r_idx;
    logic [4*WEIGHT_W-1:0] r_weights;
    logic                  r_busy;
    logic                  r_done;
    logic [ACC_W-1:0]      r_sum;
    logic                  w_accept;
    logic                  w_en;
    logic [WEIGHT_W-1:0]   w_wcur;
    logic [ACC_W-1:0]      w_acc;
    logic [ACC_W-1:0]      w_acc_nxt;

    assign w_accept = start && (r_state != RUN);
    assign w_en     = (r_state == RUN);
    assign w_wcur   = r_weights[int'(r_idx)*WEIGHT_W +: WEIGHT_W];

    // idx wraps 3->0 on the last RUN cycle, so it already reads 0 in IDLE and DONE
    assign sel  = r_idx;
    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;

    mac_acc #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W),
        .ACC_W    (ACC_W)
    ) u_mac_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_accept),
        .en      (w_en),
        .y       (y),
        .w       (w_wcur),
        .acc     (w_acc),
        .acc_nxt (w_acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= 2'd0;
            r_weights <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sum     <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state   <= RUN;
                        r_idx     <= 2'd0;
                        r_weights <= weights;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_sum   <= w_acc_nxt;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef NEURON_THRESH_EN
    logic r_fire;

    assign fire = r_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fire <= 1'b0;
        end else if (r_state == RUN && r_idx == 2'd3) begin
            r_fire <= (w_acc_nxt >= thresh);
        end
    end
`endif

    // Running accumulator value is only consumed through acc_nxt
    logic w_unused;
    assign w_unused = ^w_acc;

endmodule
`default_nettype wire
